// File: rtl/spi_rx_deser.sv
// Multi-lane SPI receive deserialiser: oversamples SCLK/CS_N/MISO in MCLK, shifts DATA_W bits per lane, checks the frame length.
// Optional frame/error counters are enabled with `define SPI_RX_FRAME_CNT_EN.
module spi_rx_deser #(
    parameter int DATA_W      = 16,
    parameter int LANES       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_EDGE = 0,
    parameter int MSB_FIRST   = 1
) (
    input  logic                      MCLK,
    input  logic                      RST_N,
    input  logic                      CS_N,
    input  logic                      SCLK,
    input  logic [LANES-1:0]          MISO,
    output logic [LANES*DATA_W-1:0]   LDATA,
    output logic                      LVALID,
`ifdef SPI_RX_FRAME_CNT_EN
    output logic [15:0]               FRAME_CNT,
    output logic [7:0]                ERR_CNT,
`endif
    output logic                      FRAME_ERR
);
    localparam int   CNT_W     = $clog2(DATA_W + 2);
    localparam logic SCLK_IDLE = (SAMPLE_EDGE != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0] cs_sync_r, sclk_sync_r, flush_r;
    logic [LANES-1:0]       miso_sync_r [SYNC_STAGES];
    logic                   cs_d_r, sclk_d_r, armed_r;
    logic                   cs_s, sclk_s;
    logic [LANES-1:0]       miso_s;
    logic                   cs_fall_s, cs_rise_s, sample_s;
    logic                   clear_s, shift_en_s, load_s, err_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [DATA_W-1:0]      shreg_r [LANES];

    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign miso_s = miso_sync_r[SYNC_STAGES-1];

    // armed_r blocks a frame that was already running when reset released
    assign cs_fall_s = armed_r & cs_d_r & ~cs_s;
    assign cs_rise_s = ~cs_d_r & cs_s;
    assign sample_s  = SCLK_IDLE ? (sclk_d_r & ~sclk_s) : (~sclk_d_r & sclk_s);

    // Input synchronisers, edge-detect delay flops and post-reset arming
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync_r   <= '1;
            sclk_sync_r <= {SYNC_STAGES{SCLK_IDLE}};
            flush_r     <= '0;
            cs_d_r      <= 1'b1;
            sclk_d_r    <= SCLK_IDLE;
            armed_r     <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                miso_sync_r[s] <= '0;
            end
        end else begin
            cs_sync_r      <= {cs_sync_r[SYNC_STAGES-2:0], CS_N};
            sclk_sync_r    <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            flush_r        <= {flush_r[SYNC_STAGES-2:0], 1'b1};
            cs_d_r         <= cs_s;
            sclk_d_r       <= sclk_s;
            armed_r        <= armed_r | (flush_r[SYNC_STAGES-1] & cs_s);
            miso_sync_r[0] <= MISO;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                miso_sync_r[s] <= miso_sync_r[s-1];
            end
        end
    end

    // FSM state register
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (cs_fall_s) state_nxt_s = ST_SHIFT; else state_nxt_s = ST_IDLE;
            ST_SHIFT: if (cs_rise_s) state_nxt_s = ST_CLOSE; else state_nxt_s = ST_SHIFT;
            ST_CLOSE: if (cs_fall_s) state_nxt_s = ST_SHIFT; else state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        clear_s    = 1'b0;
        shift_en_s = 1'b0;
        load_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_IDLE:  clear_s = cs_fall_s;
            ST_SHIFT: shift_en_s = sample_s;
            ST_CLOSE: begin
                clear_s = cs_fall_s;
                if (cnt_r == CNT_W'(DATA_W)) begin
                    load_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
            end
            default: clear_s = 1'b0;
        endcase
    end

    // Bit counter (saturates at DATA_W+1) and per-lane shift registers
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= '0;
            for (int l = 0; l < LANES; l++) begin
                shreg_r[l] <= '0;
            end
        end else if (clear_s) begin
            cnt_r <= '0;
            for (int l = 0; l < LANES; l++) begin
                shreg_r[l] <= '0;
            end
        end else if (shift_en_s) begin
            if (cnt_r != CNT_W'(DATA_W + 1)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (cnt_r < CNT_W'(DATA_W)) begin
                for (int l = 0; l < LANES; l++) begin
                    shreg_r[l] <= (MSB_FIRST != 0) ? {shreg_r[l][DATA_W-2:0], miso_s[l]}
                                                   : {miso_s[l], shreg_r[l][DATA_W-1:1]};
                end
            end
        end
    end

    // Registered result outputs
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            LDATA     <= '0;
            LVALID    <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            LVALID    <= load_s;
            FRAME_ERR <= err_s;
            if (load_s) begin
                for (int l = 0; l < LANES; l++) begin
                    LDATA[l*DATA_W +: DATA_W] <= shreg_r[l];
                end
            end
        end
    end

`ifdef SPI_RX_FRAME_CNT_EN
    // Good-frame counter wraps; error counter saturates
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            FRAME_CNT <= 16'd0;
            ERR_CNT   <= 8'd0;
        end else begin
            if (load_s) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
            if (err_s && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: three instances (default, 2-lane 12-bit, falling-edge LSB-first) share the SPI pins.
module tb_spi_rx_deser;
    logic        clk;
    logic        rst_n;
    logic        cs_n;
    logic        sclk;
    logic [1:0]  miso;
    logic [15:0] ldata_a, ldata_c;
    logic [23:0] ldata_b;
    logic        lvalid_a, lvalid_b, lvalid_c;
    logic        ferr_a, ferr_b, ferr_c;
`ifdef SPI_RX_FRAME_CNT_EN
    logic [15:0] fcnt_a, fcnt_b, fcnt_c;
    logic [7:0]  ecnt_a, ecnt_b, ecnt_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int nv_a = 0, ne_a = 0, nv_b = 0, nv_c = 0;
    int lat;
    int v0, e0;

    spi_rx_deser u_a (
        .MCLK(clk), .RST_N(rst_n), .CS_N(cs_n), .SCLK(sclk), .MISO(miso[0:0]),
        .LDATA(ldata_a), .LVALID(lvalid_a),
`ifdef SPI_RX_FRAME_CNT_EN
        .FRAME_CNT(fcnt_a), .ERR_CNT(ecnt_a),
`endif
        .FRAME_ERR(ferr_a)
    );

    spi_rx_deser #(.DATA_W(12), .LANES(2)) u_b (
        .MCLK(clk), .RST_N(rst_n), .CS_N(cs_n), .SCLK(sclk), .MISO(miso),
        .LDATA(ldata_b), .LVALID(lvalid_b),
`ifdef SPI_RX_FRAME_CNT_EN
        .FRAME_CNT(fcnt_b), .ERR_CNT(ecnt_b),
`endif
        .FRAME_ERR(ferr_b)
    );

    spi_rx_deser #(.SAMPLE_EDGE(1), .MSB_FIRST(0)) u_c (
        .MCLK(clk), .RST_N(rst_n), .CS_N(cs_n), .SCLK(sclk), .MISO(miso[0:0]),
        .LDATA(ldata_c), .LVALID(lvalid_c),
`ifdef SPI_RX_FRAME_CNT_EN
        .FRAME_CNT(fcnt_c), .ERR_CNT(ecnt_c),
`endif
        .FRAME_ERR(ferr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters, sampled away from the active edge
    always @(negedge clk) begin
        if (lvalid_a) nv_a++;
        if (ferr_a)   ne_a++;
        if (lvalid_b) nv_b++;
        if (lvalid_c) nv_c++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_fall();
        @(negedge clk);
        cs_n = 1'b0;
        cyc(4);
    endtask

    // Bits [first, first+n) of a total-bit frame; mode1 changes MISO mid-high for falling-edge capture
    task automatic send_bits(input int first, input int n, input int total,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input bit lsb, input bit mode1);
        int idx;
        for (int i = first; i < first + n; i++) begin
            idx = lsb ? i : total - 1 - i;
            if (!mode1) miso = {w1[idx], w0[idx]};
            cyc(4);
            sclk = 1'b1;
            cyc(2);
            if (mode1) miso = {w1[idx], w0[idx]};
            cyc(2);
            sclk = 1'b0;
        end
        cyc(4);
    endtask

    // Raise CS_N and report MCLK cycles until instance A strobes (99 = none within budget)
    task automatic cs_rise(output int l);
        l = 99;
        @(negedge clk);
        cs_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (l == 99 && (lvalid_a || ferr_a)) l = k;
        end
        cyc(2);
    endtask

    task automatic frame(input int total, input logic [31:0] w0, input logic [31:0] w1,
                         input bit lsb, input bit mode1, output int l);
        cs_fall();
        send_bits(0, total, total, w0, w1, lsb, mode1);
        cs_rise(l);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        miso  = 2'b00;
        cyc(3);
        check_eq("rst_ldata_a", 64'(ldata_a), 64'h0);
        check_eq("rst_lvalid_a", 64'(lvalid_a), 64'h0);
        check_eq("rst_ferr_a", 64'(ferr_a), 64'h0);
        check_eq("rst_ldata_b", 64'(ldata_b), 64'h0);
        rst_n = 1'b1;
        cyc(10);

        // Single 16-bit frame, MSB first, rising edge
        v0 = nv_a; e0 = ne_a;
        frame(16, 32'hA5C3, 32'h0, 1'b0, 1'b0, lat);
        check_eq("a_ldata", 64'(ldata_a), 64'hA5C3);
        check_eq("a_latency", 64'(lat), 64'd4);
        check_eq("a_lvalid_cnt", 64'(nv_a - v0), 64'd1);
        check_eq("a_ferr_cnt", 64'(ne_a - e0), 64'd0);

        // Two lanes, 12 bits
        v0 = nv_b;
        frame(12, 32'h123, 32'hABC, 1'b0, 1'b0, lat);
        check_eq("b_ldata", 64'(ldata_b), 64'hABC123);
        check_eq("b_lvalid_cnt", 64'(nv_b - v0), 64'd1);

        // Good frame then short and long frames
        frame(16, 32'h1234, 32'h0, 1'b0, 1'b0, lat);
        check_eq("good_ldata", 64'(ldata_a), 64'h1234);
        v0 = nv_a; e0 = ne_a;
        frame(15, 32'h7FFF, 32'h0, 1'b0, 1'b0, lat);
        check_eq("short_err_latency", 64'(lat), 64'd4);
        frame(17, 32'h1FFFF, 32'h0, 1'b0, 1'b0, lat);
        check_eq("len_err_cnt", 64'(ne_a - e0), 64'd2);
        check_eq("len_lvalid_cnt", 64'(nv_a - v0), 64'd0);
        check_eq("len_ldata_held", 64'(ldata_a), 64'h1234);

        // Falling edge, LSB first, MISO moves only while SCLK high
        v0 = nv_c;
        frame(16, 32'h0001, 32'h0, 1'b1, 1'b1, lat);
        check_eq("c_ldata_0001", 64'(ldata_c), 64'h0001);
        check_eq("c_lvalid_cnt", 64'(nv_c - v0), 64'd1);
        frame(16, 32'hA5C3, 32'h0, 1'b1, 1'b1, lat);
        check_eq("c_ldata_a5c3", 64'(ldata_c), 64'hA5C3);

        // Reset mid-frame, released while CS_N is still low
        cs_fall();
        send_bits(0, 8, 16, 32'hFFFF, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(3);
        check_eq("midrst_ldata", 64'(ldata_a), 64'h0);
        rst_n = 1'b1;
        v0 = nv_a; e0 = ne_a;
        send_bits(8, 8, 16, 32'hFFFF, 32'h0, 1'b0, 1'b0);
        cs_rise(lat);
        check_eq("midrst_lvalid_cnt", 64'(nv_a - v0), 64'd0);
        check_eq("midrst_ferr_cnt", 64'(ne_a - e0), 64'd0);
        check_eq("midrst_ldata_kept", 64'(ldata_a), 64'h0);
        frame(16, 32'h00FF, 32'h0, 1'b0, 1'b0, lat);
        check_eq("postrst_ldata", 64'(ldata_a), 64'h00FF);

`ifdef SPI_RX_FRAME_CNT_EN
        frame(16, 32'h1111, 32'h0, 1'b0, 1'b0, lat);
        frame(16, 32'h2222, 32'h0, 1'b0, 1'b0, lat);
        frame(8, 32'h00AA, 32'h0, 1'b0, 1'b0, lat);
        check_eq("frame_cnt", 64'(fcnt_a), 64'd3);
        check_eq("err_cnt", 64'(ecnt_a), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
